// File: rtl/arm_dp_pkg.sv
//------------------------------------------------------------------------------
// Module  : arm_dp_pkg
// Brief   : Shared types, encodings and helpers for the data-processing sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package arm_dp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_RN = 3'd1,
        ST_RD_RM = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    localparam logic [3:0] c_COND_EQ = 4'h0;
    localparam logic [3:0] c_COND_NE = 4'h1;
    localparam logic [3:0] c_COND_CS = 4'h2;
    localparam logic [3:0] c_COND_CC = 4'h3;
    localparam logic [3:0] c_COND_MI = 4'h4;
    localparam logic [3:0] c_COND_PL = 4'h5;
    localparam logic [3:0] c_COND_VS = 4'h6;
    localparam logic [3:0] c_COND_VC = 4'h7;
    localparam logic [3:0] c_COND_HI = 4'h8;
    localparam logic [3:0] c_COND_LS = 4'h9;
    localparam logic [3:0] c_COND_GE = 4'hA;
    localparam logic [3:0] c_COND_LT = 4'hB;
    localparam logic [3:0] c_COND_GT = 4'hC;
    localparam logic [3:0] c_COND_LE = 4'hD;
    localparam logic [3:0] c_COND_AL = 4'hE;

    localparam logic [3:0] c_OP_AND = 4'h0;
    localparam logic [3:0] c_OP_EOR = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_RSB = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_ADC = 4'h5;
    localparam logic [3:0] c_OP_SBC = 4'h6;
    localparam logic [3:0] c_OP_RSC = 4'h7;
    localparam logic [3:0] c_OP_TST = 4'h8;
    localparam logic [3:0] c_OP_TEQ = 4'h9;
    localparam logic [3:0] c_OP_CMP = 4'hA;
    localparam logic [3:0] c_OP_CMN = 4'hB;
    localparam logic [3:0] c_OP_ORR = 4'hC;
    localparam logic [3:0] c_OP_MOV = 4'hD;
    localparam logic [3:0] c_OP_BIC = 4'hE;
    localparam logic [3:0] c_OP_MVN = 4'hF;

    localparam logic [1:0] c_SH_LSL = 2'd0;
    localparam logic [1:0] c_SH_LSR = 2'd1;
    localparam logic [1:0] c_SH_ASR = 2'd2;
    localparam logic [1:0] c_SH_ROR = 2'd3;

    // Flag vector layout is {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, pass;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            c_COND_EQ: pass = z;
            c_COND_NE: pass = ~z;
            c_COND_CS: pass = c;
            c_COND_CC: pass = ~c;
            c_COND_MI: pass = n;
            c_COND_PL: pass = ~n;
            c_COND_VS: pass = v;
            c_COND_VC: pass = ~v;
            c_COND_HI: pass = c & ~z;
            c_COND_LS: pass = ~c | z;
            c_COND_GE: pass = (n == v);
            c_COND_LT: pass = (n != v);
            c_COND_GT: pass = ~z & (n == v);
            c_COND_LE: pass = z | (n != v);
            c_COND_AL: pass = 1'b1;
            default:   pass = 1'b0;
        endcase
        return pass;
    endfunction

    function automatic logic op_is_test(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        logic ar;
        case (op)
            c_OP_SUB, c_OP_RSB, c_OP_ADD, c_OP_ADC,
            c_OP_SBC, c_OP_RSC, c_OP_CMP, c_OP_CMN: ar = 1'b1;
            default:                                ar = 1'b0;
        endcase
        return ar;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_shifter.sv
//------------------------------------------------------------------------------
// Module  : dp_shifter
// Brief   : Operand2 generator: rotated immediate or shifted Rm, with carry-out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dp_shifter
    import arm_dp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              imm_i,
    input  logic [11:0]       op2_i,
    input  logic [DATA_W-1:0] rm_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    logic [4:0]        w_rot;
    logic [DATA_W-1:0] w_imm8;
    logic [DATA_W-1:0] w_imm;
    logic [4:0]        w_amt;
    logic [1:0]        w_type;
    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr_in;
    logic [DATA_W:0]   w_asr;
    logic [DATA_W-1:0] w_ror;

    assign w_rot    = {op2_i[11:8], 1'b0};
    assign w_imm8   = {{(DATA_W-8){1'b0}}, op2_i[7:0]};
    assign w_imm    = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - {1'b0, w_rot}));
    assign w_amt    = op2_i[11:7];
    assign w_type   = op2_i[6:5];

    // The extra bit below/above the word captures the last bit shifted out.
    assign w_lsl    = {1'b0, rm_i} << w_amt;
    assign w_lsr    = {rm_i, 1'b0} >> w_amt;
    assign w_asr_in = {rm_i, 1'b0};
    assign w_asr    = $signed(w_asr_in) >>> w_amt;
    assign w_ror    = (rm_i >> w_amt) | (rm_i << (6'd32 - {1'b0, w_amt}));

    always_comb begin
        res_o   = rm_i;
        carry_o = cin_i;
        if (imm_i) begin
            res_o   = w_imm;
            carry_o = (w_rot != 5'd0) ? w_imm[DATA_W-1] : cin_i;
        end else if (w_amt != 5'd0) begin
            case (w_type)
                c_SH_LSL: begin
                    res_o   = w_lsl[DATA_W-1:0];
                    carry_o = w_lsl[DATA_W];
                end
                c_SH_LSR: begin
                    res_o   = w_lsr[DATA_W:1];
                    carry_o = w_lsr[0];
                end
                c_SH_ASR: begin
                    res_o   = w_asr[DATA_W:1];
                    carry_o = w_asr[0];
                end
                default: begin
                    res_o   = w_ror;
                    carry_o = w_ror[DATA_W-1];
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dp_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : dp_seq_ctrl
// Brief   : Multi-cycle sequencer for ARM data-processing instructions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dp_seq_ctrl
    import arm_dp_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [3:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [3:0]        alu_nzcv,
    output logic [3:0]        nzcv,
    output logic              done,
    output logic              skipped,
    output logic              err
);

    state_t            state_q;
    logic              i_q;
    logic [3:0]        op_q;
    logic              s_q;
    logic [3:0]        rn_addr_q;
    logic [3:0]        rd_q;
    logic [11:0]       op2_q;
    logic              kill_q;
    logic [DATA_W-1:0] rn_val_q;
    logic [DATA_W-1:0] rm_val_q;
    logic [3:0]        raddr_q;
    logic              rf_we_q;
    logic [3:0]        rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [3:0]        nzcv_q;
    logic [3:0]        flags_new_q;
    logic              flags_upd_q;
    logic              done_q;
    logic              skipped_q;
    logic              err_q;

    logic [3:0]        flags_d;
    logic              w_err;
    logic              w_kill;
    logic [DATA_W-1:0] w_op2;
    logic              w_sh_carry;
    logic              w_unused_bits;

    assign w_unused_bits = ^instr[27:26];

    // Flags cannot change between acceptance and RD_RN, so the condition is
    // resolved at transfer and the skip outputs come straight from registers.
    assign w_err  = ~instr[25] & instr[4];
    assign w_kill = ~cond_pass(instr[31:28], nzcv_q) | w_err;

    dp_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .imm_i   (i_q),
        .op2_i   (op2_q),
        .rm_i    (rm_val_q),
        .cin_i   (nzcv_q[1]),
        .res_o   (w_op2),
        .carry_o (w_sh_carry)
    );

    assign instr_ready = (state_q == ST_IDLE);
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_op      = op_q;
    assign alu_a       = rn_val_q;
    assign alu_b       = w_op2;
    assign alu_cin     = nzcv_q[1];
    assign nzcv        = nzcv_q;
    assign done        = done_q;
    assign skipped     = skipped_q;
    assign err         = err_q;

    always_comb begin
        case (state_q)
            ST_IDLE:  rf_raddr = instr[19:16];
            ST_RD_RN: rf_raddr = rn_addr_q;
            ST_RD_RM: rf_raddr = op2_q[3:0];
            default:  rf_raddr = raddr_q;
        endcase
    end

    always_comb begin
        if (op_is_arith(op_q)) begin
            flags_d = alu_nzcv;
        end else begin
            flags_d = {alu_nzcv[3:2], w_sh_carry, nzcv_q[0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            i_q         <= 1'b0;
            op_q        <= 4'd0;
            s_q         <= 1'b0;
            rn_addr_q   <= 4'd0;
            rd_q        <= 4'd0;
            op2_q       <= 12'd0;
            kill_q      <= 1'b0;
            rn_val_q    <= '0;
            rm_val_q    <= '0;
            raddr_q     <= 4'd0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 4'd0;
            rf_wdata_q  <= '0;
            nzcv_q      <= FLAGS_RST;
            flags_new_q <= 4'd0;
            flags_upd_q <= 1'b0;
            done_q      <= 1'b0;
            skipped_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            raddr_q <= rf_raddr;
            case (state_q)
                ST_IDLE: begin
                    rf_we_q   <= 1'b0;
                    done_q    <= 1'b0;
                    skipped_q <= 1'b0;
                    err_q     <= 1'b0;
                    if (instr_valid) begin
                        i_q       <= instr[25];
                        op_q      <= instr[24:21];
                        s_q       <= instr[20];
                        rn_addr_q <= instr[19:16];
                        rd_q      <= instr[15:12];
                        op2_q     <= instr[11:0];
                        kill_q    <= w_kill;
                        done_q    <= w_kill;
                        skipped_q <= w_kill;
                        err_q     <= w_err;
                        state_q   <= ST_RD_RN;
                    end
                end
                ST_RD_RN: begin
                    done_q    <= 1'b0;
                    skipped_q <= 1'b0;
                    err_q     <= 1'b0;
                    rn_val_q  <= rf_rdata;
                    if (kill_q) begin
                        state_q <= ST_IDLE;
                    end else if (i_q) begin
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_RD_RM;
                    end
                end
                ST_RD_RM: begin
                    rm_val_q <= rf_rdata;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    rf_we_q     <= ~op_is_test(op_q);
                    rf_waddr_q  <= rd_q;
                    rf_wdata_q  <= alu_res;
                    flags_new_q <= flags_d;
                    flags_upd_q <= s_q | op_is_test(op_q);
                    done_q      <= 1'b1;
                    skipped_q   <= 1'b0;
                    err_q       <= 1'b0;
                    state_q     <= ST_WB;
                end
                ST_WB: begin
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (flags_upd_q) begin
                        nzcv_q <= flags_new_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
